// File: rtl/clq_walk_ctrl.sv
// Round-robin scheduler for unit-clause literal requests: looks up the CLQ head
// pointer for the winning literal, then walks the node list one beat at a time.
module clq_walk_ctrl #(
  parameter int NUM_REQ  = 4,
  parameter int LIT_W    = 8,
  parameter int PTR_W    = 4,
  parameter int MAX_WALK = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*LIT_W-1:0] req_lit,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic                     load_busy,
  output logic [LIT_W-1:0]         uc_rqst,
  output logic                     uc_rqst_valid,
  input  logic [PTR_W-1:0]         init_ptr,
  input  logic                     init_ptr_valid,
  output logic [PTR_W-1:0]         cnf_idx,
  input  logic [PTR_W-1:0]         node_next_ptr,
  output logic                     bcp_node_valid,
  input  logic                     bcp_node_ready,
  output logic [PTR_W-1:0]         bcp_node_idx,
  output logic                     walk_done,
  output logic                     walk_err,
  output logic                     busy
);

  localparam int RR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_WALK) + 1;

  typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_WALK, S_DONE} state_t;

  state_t             r_state;
  logic [RR_W-1:0]    r_rr;
  logic [LIT_W-1:0]   r_lit;
  logic [PTR_W-1:0]   r_cur;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_err;

  logic               w_any;
  logic [RR_W-1:0]    w_win;
  logic [RR_W-1:0]    w_rr_nxt;
  logic               w_grant_en;
  logic [CNT_W-1:0]   w_cnt_inc;
  int unsigned        w_idx;

  // First valid requester at or above r_rr, wrapping at NUM_REQ.
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    w_idx = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = (int'(r_rr) + k) % NUM_REQ;
      if (!w_any && req_valid[w_idx]) begin
        w_any = 1'b1;
        w_win = RR_W'(w_idx);
      end
    end
  end

  assign w_rr_nxt   = (w_win == RR_W'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;
  assign w_grant_en = (r_state == S_IDLE) && !load_busy && w_any && !rst_n;
  assign req_ready  = w_grant_en ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << w_win) : '0;
  assign w_cnt_inc  = r_cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_state <= S_IDLE;
      r_rr    <= '0;
      r_lit   <= '0;
      r_cur   <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant_en) begin
            r_lit   <= req_lit[w_win*LIT_W +: LIT_W];
            r_rr    <= w_rr_nxt;
            r_state <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (init_ptr_valid) begin
            if (init_ptr == '0) begin
              r_state <= S_DONE;
            end else begin
              r_cur   <= init_ptr;
              r_cnt   <= '0;
              r_state <= S_WALK;
            end
          end
        end
        S_WALK: begin
          if (bcp_node_ready) begin
            r_cnt <= w_cnt_inc;
            if (node_next_ptr == '0) begin
              r_state <= S_DONE;
            end else if (w_cnt_inc == CNT_W'(MAX_WALK)) begin
              // Bound hit: treat the list as cyclic and terminate with error.
              r_err   <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_cur <= node_next_ptr;
            end
          end
        end
        S_DONE: begin
          r_err   <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign uc_rqst_valid  = (r_state == S_LOOKUP);
  assign uc_rqst        = (r_state == S_LOOKUP) ? r_lit : '0;
  assign bcp_node_valid = (r_state == S_WALK);
  assign cnf_idx        = (r_state == S_WALK) ? r_cur : '0;
  assign bcp_node_idx   = (r_state == S_WALK) ? r_cur : '0;
  assign walk_done      = (r_state == S_DONE);
  assign walk_err       = (r_state == S_DONE) && r_err;
  assign busy           = (r_state != S_IDLE);

endmodule

// File: doc/clq_walk_ctrl.md
Name: clq_walk_ctrl

Overview:
- Scheduler in front of the clause-literal queue (CLQ).
- Arbitrates unit-clause (UC) literal requests from NUM_REQ requesters, round-robin.
- For the winning literal: issues the head-pointer lookup to the CLQ, then walks the linked node list one node per accepted beat, presenting each node index to the BCP engine over a valid/ready handshake.
- Blocks new lookups while the CLQ is being loaded and bounds each walk to guard against cyclic lists.

Parameters:
- NUM_REQ, 4, number of UC literal requesters.
- LIT_W, 8, literal width (MSB = polarity, matches CLQ lit_t).
- PTR_W, 4, CLQ node pointer width (log2 CLQ DEPTH); pointer value 0 is reserved as null/end-of-list.
- MAX_WALK, 16, maximum nodes emitted per walk before forced termination.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-high (asserted = 1 resets the block).
- req_valid  in  NUM_REQ  per-requester literal valid.
- req_lit  in  NUM_REQ*LIT_W  per-requester literal, requester i at bits [i*LIT_W +: LIT_W].
- req_ready  out  NUM_REQ  one-hot grant/accept pulse.
- load_busy  in  1  CLQ node/dummy load in progress; blocks new grants.
- uc_rqst  out  LIT_W  literal sent to CLQ for head lookup.
- uc_rqst_valid  out  1  lookup strobe.
- init_ptr  in  PTR_W  head pointer returned by CLQ.
- init_ptr_valid  in  1  init_ptr qualifier.
- cnf_idx  out  PTR_W  CLQ read index.
- node_next_ptr  in  PTR_W  next-pointer field of the node at cnf_idx (combinational CLQ read).
- bcp_node_valid  out  1  node offered to BCP.
- bcp_node_ready  in  1  BCP accepts node.
- bcp_node_idx  out  PTR_W  index of the offered node.
- walk_done  out  1  one-cycle pulse at end of every walk.
- walk_err  out  1  one-cycle pulse, coincident with walk_done, when MAX_WALK was hit.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst_n=1 at a clk edge):
  - state=IDLE, rr_ptr=0, cur_ptr=0, count=0, err flag=0.
  - All outputs 0.
  - Reset mid-walk aborts the walk with no walk_done pulse.
- States: IDLE, LOOKUP, WALK, DONE.
- IDLE:
  - Grants only if load_busy=0 and any req_valid=1.
  - Winner is the first valid requester searching upward from rr_ptr, wrapping at NUM_REQ.
  - req_ready[winner]=1 combinationally that cycle; the literal is latched; rr_ptr <= (winner+1) mod NUM_REQ; next state LOOKUP.
  - Otherwise req_ready=0 and the block stays in IDLE.
- LOOKUP:
  - uc_rqst_valid=1, uc_rqst=latched literal.
  - If init_ptr_valid=1: if init_ptr==0, go to DONE (empty list, zero nodes); else cur_ptr<=init_ptr, count<=0, go to WALK.
  - If init_ptr_valid=0: stay in LOOKUP and keep the request asserted.
- WALK:
  - cnf_idx=cur_ptr, bcp_node_idx=cur_ptr, bcp_node_valid=1.
  - Outputs stay stable while bcp_node_ready=0 (no drop, no advance).
  - On a beat with bcp_node_ready=1, count<=count+1, then:
    - node_next_ptr==0: go to DONE.
    - else if count+1==MAX_WALK: set err flag, go to DONE.
    - else cur_ptr<=node_next_ptr, stay in WALK.
- DONE:
  - walk_done=1 and walk_err=err flag for exactly one cycle.
  - Clear err flag; go to IDLE.
  - No grant occurs in DONE, so there is a minimum of 1 idle cycle between walks.
- Outside their respective states, cnf_idx, uc_rqst and bcp_node_idx drive 0.
- load_busy affects only grant in IDLE. An in-flight walk completes regardless.
- count is a $clog2(MAX_WALK)+1 bit counter and never wraps.
- Latency, single-node list with no stalls:
  - grant at cycle T, LOOKUP at T+1, node offered at T+2, walk_done at T+3, next grant at T+4 at earliest.
- A requester holding req_valid without being granted must keep req_lit stable. The block reads req_lit only on the grant cycle.

Test Plan:
- Reset, then idle with no requests -> all outputs 0, busy=0 for 10 cycles; reset asserted mid-WALK -> next cycle busy=0, walk_done never pulses.
- Requester 0 lit 8'h03; CLQ returns init_ptr=5; next ptrs 5->9->0; ready always 1 -> uc_rqst=8'h03 for one cycle; bcp_node_idx 5 then 9 on consecutive cycles; walk_done one cycle after idx 9.
- All 4 requesters valid continuously -> grants in order 0,1,2,3,0 over five walks; no requester granted twice in a row.
- init_ptr=0 -> no bcp_node_valid; walk_done at LOOKUP+1; walk_err=0.
- Node 3 with next=3 (self-loop), MAX_WALK=16 -> exactly 16 beats with idx 3, then walk_done=1 and walk_err=1 together.
- bcp_node_ready low for 4 cycles on the second node; separately, load_busy=1 with req_valid=1 -> idx held for all 4 stall cycles; no req_ready while load_busy=1; grant on the first cycle after load_busy falls.
